// File: rtl/spi_ram_pkg.sv
// Shared command encodings and FSM states for the SPI-attached burst RAM.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR  = 2'b00,
        CMD_WR_DATA  = 2'b01,
        CMD_RD_ADDR  = 2'b10,
        CMD_RD_BURST = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// MEM_DEPTH x DATA_W storage with one synchronous write and one synchronous read port.
// Addresses at or beyond MEM_DEPTH never write and always read back as zero.
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_C = MEM_DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              w_in_range;
    logic              r_in_range;

    assign w_in_range = ({1'b0, waddr} < DEPTH_C);
    assign r_in_range = ({1'b0, raddr} < DEPTH_C);

    always_ff @(posedge clk) begin
        if (we && w_in_range) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the transmit data, so it is cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_in_range ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/spi_burst_ram.sv
// Command decoder for the SPI-attached RAM: auto-incrementing pointers,
// multi-word read bursts and a tx_valid/tx_ready handshake toward the SPI transmitter.
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  ADDR_W    = 8,
    parameter int  MEM_DEPTH = 256,
    localparam int PAY_W     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PAY_W+1:0]   din,
    input  logic               rx_valid,
    input  logic               tx_ready,
    output logic [DATA_W-1:0]  dout,
    output logic               tx_valid,
    output logic               busy,
    output logic               cmd_drop
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_e            state;
    cmd_e              cmd;
    logic [PAY_W-1:0]  payload;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [PAY_W-1:0]  remain;
    logic              mem_we;
    logic              mem_re;
    logic              idle_cmd;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    assign cmd      = cmd_e'(din[PAY_W+1:PAY_W]);
    assign payload  = din[PAY_W-1:0];
    assign idle_cmd = rst_n && (state == IDLE) && rx_valid;

    // A read is issued on burst start and on every accepted word that is not the last.
    assign mem_we = idle_cmd && (cmd == CMD_WR_DATA);
    assign mem_re = (idle_cmd && (cmd == CMD_RD_BURST)) ||
                    (rst_n && (state == BURST) && tx_ready && (remain != '0));

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (payload[DATA_W-1:0]),
        .re    (mem_re),
        .raddr (rd_ptr),
        .rdata (dout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            remain   <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            cmd_drop <= 1'b0;
        end else begin
            cmd_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        case (cmd)
                            CMD_WR_ADDR: wr_ptr <= payload[ADDR_W-1:0];
                            CMD_WR_DATA: wr_ptr <= next_ptr(wr_ptr);
                            CMD_RD_ADDR: rd_ptr <= payload[ADDR_W-1:0];
                            CMD_RD_BURST: begin
                                rd_ptr   <= next_ptr(rd_ptr);
                                remain   <= payload;
                                tx_valid <= 1'b1;
                                busy     <= 1'b1;
                                state    <= BURST;
                            end
                            default: ;
                        endcase
                    end
                end
                BURST: begin
                    if (rx_valid) begin
                        cmd_drop <= 1'b1;
                    end
                    if (tx_ready) begin
                        if (remain == '0) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            rd_ptr <= next_ptr(rd_ptr);
                            remain <= remain - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_ram.sv
// Randomized self-checking bench for spi_burst_ram against a behavioural RAM model.
module tb_spi_burst_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int PAY_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PAY_W+1:0]  din = '0;
    logic              rx_valid = 1'b0;
    logic              tx_ready = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              busy;
    logic              cmd_drop;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mem [256];
    int m_wr = 0;
    int m_rd = 0;

    spi_burst_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .tx_ready (tx_ready),
        .dout     (dout),
        .tx_valid (tx_valid),
        .busy     (busy),
        .cmd_drop (cmd_drop)
    );

    always #5 clk = ~clk;

    function automatic int nxt(input int p);
        return (p == DEPTH - 1) ? 0 : (p + 1) % 256;
    endfunction

    function automatic int mread(input int a);
        return (a < DEPTH) ? m_mem[a] : 0;
    endfunction

    task automatic drive_word(input logic [1:0] c, input int p);
        din      = {c, 8'(p)};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic send(input logic [1:0] c, input int p);
        drive_word(c, p);
        case (c)
            2'b00: m_wr = p & 255;
            2'b01: begin
                if (m_wr < DEPTH) m_mem[m_wr] = p & 255;
                m_wr = nxt(m_wr);
            end
            2'b10: m_rd = p & 255;
            default: ;
        endcase
    endtask

    // mode 0: always ready, 1: random ready, 2: three stall cycles before each word
    task automatic run_burst(input int plen, input int mode);
        logic [7:0] exp_q[$];
        int k, stall, cyc;
        bit rdy;
        for (int i = 0; i <= plen; i++) begin
            exp_q.push_back(8'(mread(m_rd)));
            m_rd = nxt(m_rd);
        end
        tx_ready = 1'b1;
        drive_word(2'b11, plen);
        k = 0; stall = 0; cyc = 0;
        while (k <= plen) begin
            n_tests++;
            if (tx_valid !== 1'b1 || busy !== 1'b1 || dout !== exp_q[k]) begin
                n_fail++;
                $display("FAIL burst word %0d/%0d mode %0d: dout=%h tx_valid=%b busy=%b, expected dout=%h tx_valid=1 busy=1",
                         k, plen + 1, mode, dout, tx_valid, busy, exp_q[k]);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (stall == 3);
            endcase
            tx_ready = rdy;
            @(posedge clk);
            #1;
            if (rdy) begin k++; stall = 0; end
            else stall++;
            cyc++;
            if (cyc > (plen + 1) * 12 + 20) begin
                n_tests++; n_fail++;
                $display("FAIL burst timeout: delivered %0d of %0d words", k, plen + 1);
                break;
            end
        end
        tx_ready = 1'b0;
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || cmd_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL burst end: tx_valid=%b busy=%b cmd_drop=%b, expected all 0", tx_valid, busy, cmd_drop);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dout !== '0 || tx_valid !== 1'b0 || busy !== 1'b0 || cmd_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: dout=%h tx_valid=%b busy=%b cmd_drop=%b, expected 0/0/0/0",
                     dout, tx_valid, busy, cmd_drop);
        end
        rst_n = 1'b1;
        m_wr = 0; m_rd = 0;
        // fill memory from the reset wr_ptr, then read from the reset rd_ptr
        for (int i = 0; i < DEPTH; i++) send(2'b01, int'($urandom_range(0, 255)));
        run_burst(0, 0);
    endtask

    task automatic test_single();
        send(2'b00, 'h10);
        send(2'b01, 'hA5);
        send(2'b10, 'h10);
        run_burst(0, 0);
    endtask

    task automatic test_autoinc();
        send(2'b00, 'h20);
        for (int v = 1; v <= 4; v++) send(2'b01, v);
        send(2'b10, 'h20);
        run_burst(3, 0);
        run_burst(0, 0);
    endtask

    task automatic test_wrap();
        send(2'b00, 199);
        send(2'b01, 'h11);
        send(2'b01, 'h22);
        send(2'b10, 199);
        run_burst(1, 0);
    endtask

    task automatic test_out_of_range();
        send(2'b00, 210);
        send(2'b01, 'h99);
        send(2'b10, 210);
        run_burst(1, 0);
        send(2'b10, 255);
        run_burst(1, 1);
    endtask

    task automatic test_backpressure();
        send(2'b10, int'($urandom_range(0, DEPTH - 1)));
        run_burst(2, 2);
    endtask

    task automatic test_drop();
        logic [7:0] e0, e1;
        send(2'b00, 'h50);
        send(2'b01, 'h31);
        send(2'b01, 'h32);
        send(2'b10, 'h50);
        e0 = 8'(mread('h50));
        e1 = 8'(mread('h51));
        m_rd = 'h52;
        tx_ready = 1'b0;
        drive_word(2'b11, 1);
        din = {2'b01, 8'h77};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        din = '0;
        n_tests++;
        if (cmd_drop !== 1'b1 || tx_valid !== 1'b1 || dout !== e0) begin
            n_fail++;
            $display("FAIL drop pulse: cmd_drop=%b tx_valid=%b dout=%h, expected 1/1/%h", cmd_drop, tx_valid, dout, e0);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (cmd_drop !== 1'b0 || dout !== e0) begin
            n_fail++;
            $display("FAIL drop single cycle: cmd_drop=%b dout=%h, expected 0/%h", cmd_drop, dout, e0);
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (tx_valid !== 1'b1 || dout !== e1) begin
            n_fail++;
            $display("FAIL drop second word: tx_valid=%b dout=%h, expected 1/%h", tx_valid, dout, e1);
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop burst end: tx_valid=%b busy=%b, expected 0/0", tx_valid, busy);
        end
        // wr_ptr must still point at 0x52 and 0x53 must be untouched
        send(2'b01, 'h5C);
        send(2'b10, 'h52);
        run_burst(1, 0);
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] w0, w1;
        send(2'b00, 'h40);
        for (int i = 0; i < 8; i++) send(2'b01, int'($urandom_range(0, 255)));
        send(2'b10, 'h40);
        w0 = 8'(mread('h40));
        w1 = 8'(mread('h41));
        tx_ready = 1'b1;
        drive_word(2'b11, 7);
        @(posedge clk);
        #1;
        n_tests++;
        if (dout !== w1 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid-burst word 2: dout=%h tx_valid=%b, expected %h/1 (first %h)", dout, tx_valid, w1, w0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tx_ready = 1'b0;
        n_tests++;
        if (dout !== '0 || tx_valid !== 1'b0 || busy !== 1'b0 || cmd_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL mid-burst reset: dout=%h tx_valid=%b busy=%b cmd_drop=%b, expected 0/0/0/0",
                     dout, tx_valid, busy, cmd_drop);
        end
        m_wr = 0; m_rd = 0;
        send(2'b01, int'($urandom_range(0, 255)));
        run_burst(0, 0);
        send(2'b10, 'h40);
        run_burst(7, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: send(2'b00, int'($urandom_range(0, 255)));
                1: send(2'b01, int'($urandom_range(0, 255)));
                2: send(2'b10, int'($urandom_range(0, 255)));
                default: run_burst(int'($urandom_range(0, 6)), int'($urandom_range(0, 1)));
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_autoinc();
        test_wrap();
        test_out_of_range();
        test_backpressure();
        test_drop();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_burst_ram.md
# spi_burst_ram

Parametrised command-driven single-port RAM that sits behind the SPI slave and decodes its received words (2-bit command + payload). Successor to the fixed 256x8 SPI RAM: configurable width and depth, auto-incrementing write and read pointers, multi-word read bursts, and a tx_valid/tx_ready handshake toward the SPI slave's transmit path.

## Interface
- DATA_W, 8, RAM word width
- ADDR_W, 8, address width
- MEM_DEPTH, 256, number of words; 2 ≤ MEM_DEPTH ≤ 2**ADDR_W; need not be a power of two
- PAY_W, max(ADDR_W, DATA_W), derived payload width; not overridden

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- din  in  PAY_W+2  din[PAY_W+1:PAY_W] = command, din[PAY_W-1:0] = payload
- rx_valid  in  1  din valid this cycle; single-cycle strobe per word
- tx_ready  in  1  SPI transmit path has accepted dout
- dout  out  DATA_W  read data
- tx_valid  out  1  dout valid; held until tx_ready
- busy  out  1  read burst in progress
- cmd_drop  out  1  one-cycle pulse: a command arrived while busy and was discarded

## Operation
- Commands, executed only in IDLE when rx_valid=1:
  - 00 WR_ADDR: wr_ptr ← din[ADDR_W-1:0]
  - 01 WR_DATA: mem[wr_ptr] ← din[DATA_W-1:0]; wr_ptr ← next(wr_ptr)
  - 10 RD_ADDR: rd_ptr ← din[ADDR_W-1:0]
  - 11 RD_BURST: length = payload+1 words. dout ← mem[rd_ptr]; rd_ptr ← next(rd_ptr); remain ← payload; tx_valid ← 1; go to BURST.
- next(p) = (p == MEM_DEPTH-1) ? 0 : p+1. Wrap-around applies to both pointers.
- Pointer loads ≥ MEM_DEPTH are reduced modulo nothing: the address is taken as given, write is suppressed and read returns 0. Pointer still increments by next().
- BURST state: busy=1, tx_valid=1.
  - If tx_ready=1 and remain==0: tx_valid ← 0; go to IDLE.
  - If tx_ready=1 and remain≠0: dout ← mem[rd_ptr]; rd_ptr ← next(rd_ptr); remain ← remain-1.
  - If tx_ready=0: dout, rd_ptr and remain hold.
- rx_valid=1 in BURST: command ignored with no state change; cmd_drop=1 next cycle.
- Memory contents are not reset. rst_n clears dout=0, tx_valid=0, busy=0, cmd_drop=0, wr_ptr=0, rd_ptr=0, remain=0, and state=IDLE, including mid-burst.

## Timing
- All outputs are registered.
- WR_DATA at edge N: data is readable by a RD_BURST accepted at edge N+1 or later.
- RD_BURST accepted at edge N: dout and tx_valid are valid after edge N; busy=1 after edge N.
- With tx_ready held at 1, the burst delivers one word per cycle. The last word is accepted at edge N+length, and tx_valid=busy=0 after that edge.
- A new command is accepted in the cycle after busy falls.
- tx_ready is ignored while tx_valid=0.
- cmd_drop is high for exactly one cycle per dropped word.

## Structure
- Package spi_ram_pkg:
  - command encodings CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_BURST
  - state enum {IDLE, BURST}
- Sub-module spi_ram_mem: MEM_DEPTH x DATA_W array with a synchronous write port and a synchronous read port.
  - Out-of-range handling lives here: write is gated and read data is forced to 0.
  - The top level holds the FSM, the pointers, the remain counter and the handshake.

## Test plan
- Write then single read, defaults:
  - Stimulus: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_BURST 0, tx_ready=1.
  - Required: dout=0xA5 with tx_valid for one cycle; busy for one cycle.
- Auto-increment burst:
  - Stimulus: WR_ADDR 0x20, WR_DATA 0x01..0x04, RD_ADDR 0x20, RD_BURST 3, tx_ready=1.
  - Required: dout 0x01, 0x02, 0x03, 0x04 on consecutive cycles; rd_ptr=0x24 at the end.
- Wrap with MEM_DEPTH=200, ADDR_W=8:
  - Stimulus: WR_ADDR 199, WR_DATA 0x11, 0x22; RD_ADDR 199, RD_BURST 1.
  - Required: mem[199]=0x11, mem[0]=0x22; dout 0x11 then 0x22.
- Backpressure:
  - Stimulus: RD_BURST 2 with tx_ready low for 3 cycles before each word.
  - Required: dout stable while tx_valid=1 and tx_ready=0; exactly 3 words delivered, none skipped or repeated.
- Drop during burst:
  - Stimulus: send WR_DATA 0x77 while busy.
  - Required: cmd_drop pulses once; memory and wr_ptr unchanged; burst output unaffected.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 in the 2nd word of an 8-word burst.
  - Required: tx_valid=busy=0, dout=0 after the edge; pointers=0; previously written memory preserved on a later read.
